// File: rtl/dcache_prefetcher.sv
// Next-line prefetch buffer between the Dcache refill port and the AXI read port.
// Define DCACHE_PREFETCH_EN to build the prefetch buffer; otherwise line reads pass straight through.
module dcache_prefetcher #(
   parameter int LINE_BYTES = 16,
   parameter int ENTRY_NUM  = 2,
   localparam int LINE_BITS = 8*LINE_BYTES,
   localparam int OFS       = $clog2(LINE_BYTES)
) (
   input  logic                   clk,
   input  logic                   resetn,
   input  logic                   cache_rd_req,
   input  logic                   cache_rd_type,
   input  logic [31:0]            cache_rd_addr,
   output logic                   cache_rd_rdy,
   output logic                   cache_ret_valid,
   output logic [LINE_BITS-1:0]   cache_ret_data,
   input  logic                   cache_inv_valid,
   input  logic [31:0]            cache_inv_addr,
   output logic                   axi_rd_req,
   output logic [1:0]             axi_rd_type,
   output logic [31:0]            axi_rd_addr,
   input  logic                   axi_rd_rdy,
   input  logic                   axi_ret_valid,
   input  logic [2*LINE_BITS-1:0] axi_ret_data,
   input  logic                   axi_ret_half
);

   typedef enum logic [4:0] {
      IDLE    = 5'b00001,
      HIT     = 5'b00010,
      MISS    = 5'b00100,
      FILL    = 5'b01000,
      UNCACHE = 5'b10000
   } state_t;

   state_t state;
   logic   acc;
   logic   unused_ok;

   assign axi_rd_req   = (state == IDLE) & cache_rd_req;
   assign cache_rd_rdy = (state == IDLE) & axi_rd_rdy;
   assign acc          = axi_rd_req & axi_rd_rdy;

`ifdef DCACHE_PREFETCH_EN
   localparam int IW = (ENTRY_NUM > 1) ? $clog2(ENTRY_NUM) : 1;

   logic [ENTRY_NUM-1:0] valid;
   logic [31:OFS]        tag  [ENTRY_NUM];
   logic [LINE_BITS-1:0] data [ENTRY_NUM];
   logic [IW-1:0]        ptr, tgt, hit_idx, vic;
   logic [31:OFS]        fill_tag;
   logic                 discard, ret_valid;
   logic [LINE_BITS-1:0] ret_data;
   logic [ENTRY_NUM-1:0] inv_hit, dup_hit, clr;
   logic                 hit, inv_same, inv_next, inv_fill, pend;
   logic [31:0]          next_addr;

   assign unused_ok = ^cache_inv_addr[OFS-1:0];
   assign next_addr = cache_rd_addr + 32'(LINE_BYTES);
   assign inv_same  = cache_inv_valid
                    & (cache_inv_addr[31:OFS] == cache_rd_addr[31:OFS]);
   assign inv_next  = cache_inv_valid
                    & (cache_inv_addr[31:OFS] == next_addr[31:OFS]);
   assign pend      = (state == HIT) | (state == MISS) | (state == FILL);
   assign inv_fill  = pend & cache_inv_valid
                    & (cache_inv_addr[31:OFS] == fill_tag);

   // An invalidate racing the lookup on the same line forces a miss.
   always_comb begin
      hit     = 1'b0;
      hit_idx = '0;
      inv_hit = '0;
      dup_hit = '0;
      for (int i = 0; i < ENTRY_NUM; i++) begin
         inv_hit[i] = cache_inv_valid & valid[i]
                    & (tag[i] == cache_inv_addr[31:OFS]);
         dup_hit[i] = valid[i] & (tag[i] == next_addr[31:OFS]);
         if (valid[i] && tag[i] == cache_rd_addr[31:OFS]) begin
            hit     = 1'b1;
            hit_idx = IW'(i);
         end
      end
      hit = hit & cache_rd_req & cache_rd_type & ~inv_same;
   end

   // Dropping any copy of the prefetch line keeps tags unique.
   always_comb begin
      vic = hit ? hit_idx : ptr;
      clr = inv_hit;
      if (acc & cache_rd_type)
         clr = clr | dup_hit | (ENTRY_NUM'(1) << vic);
   end

   assign axi_rd_type = !cache_rd_type ? 2'b00 : (hit ? 2'b01 : 2'b10);
   assign axi_rd_addr = hit ? next_addr : cache_rd_addr;
   assign cache_ret_data = (state == HIT) ? ret_data
                                          : axi_ret_data[LINE_BITS-1:0];

   always_comb begin
      cache_ret_valid = 1'b0;
      case (state)
         HIT:     cache_ret_valid = ret_valid;
         MISS:    cache_ret_valid = axi_ret_half;
         UNCACHE: cache_ret_valid = axi_ret_valid;
         default: cache_ret_valid = 1'b0;
      endcase
   end

   always_ff @(posedge clk) begin
      if (!resetn) begin
         state     <= IDLE;
         valid     <= '0;
         ptr       <= '0;
         tgt       <= '0;
         fill_tag  <= '0;
         discard   <= 1'b0;
         ret_valid <= 1'b0;
         ret_data  <= '0;
         for (int i = 0; i < ENTRY_NUM; i++) begin
            tag[i]  <= '0;
            data[i] <= '0;
         end
      end else begin
         ret_valid <= 1'b0;
         valid     <= valid & ~clr;
         case (state)
            IDLE: if (acc) begin
               if (!cache_rd_type) begin
                  state <= UNCACHE;
               end else begin
                  tgt      <= vic;
                  fill_tag <= next_addr[31:OFS];
                  discard  <= inv_next;
                  if (hit) begin
                     ret_data  <= data[hit_idx];
                     ret_valid <= 1'b1;
                     state     <= HIT;
                  end else begin
                     state <= MISS;
                  end
               end
            end
            UNCACHE: if (axi_ret_valid) state <= IDLE;
            MISS: begin
               discard <= discard | inv_fill;
               if (axi_ret_half) state <= FILL;
            end
            FILL: if (axi_ret_valid) begin
               data[tgt]  <= axi_ret_data[2*LINE_BITS-1:LINE_BITS];
               tag[tgt]   <= fill_tag;
               valid[tgt] <= ~(discard | inv_fill);
               ptr        <= (ptr == IW'(ENTRY_NUM-1)) ? '0 : ptr + 1'b1;
               discard    <= 1'b0;
               state      <= IDLE;
            end else begin
               discard <= discard | inv_fill;
            end
            HIT: if (axi_ret_valid) begin
               data[tgt]  <= axi_ret_data[LINE_BITS-1:0];
               tag[tgt]   <= fill_tag;
               valid[tgt] <= ~(discard | inv_fill);
               discard    <= 1'b0;
               state      <= IDLE;
            end else begin
               discard <= discard | inv_fill;
            end
            default: state <= IDLE;
         endcase
      end
   end
`else
   assign unused_ok = ^{cache_inv_valid, cache_inv_addr, axi_ret_half,
                        axi_ret_data[2*LINE_BITS-1:LINE_BITS]};
   assign axi_rd_type    = cache_rd_type ? 2'b01 : 2'b00;
   assign axi_rd_addr    = cache_rd_addr;
   assign cache_ret_data = axi_ret_data[LINE_BITS-1:0];
   assign cache_ret_valid = ((state == MISS) | (state == UNCACHE))
                          & axi_ret_valid;

   always_ff @(posedge clk) begin
      if (!resetn) begin
         state <= IDLE;
      end else begin
         case (state)
            IDLE:          if (acc) state <= cache_rd_type ? MISS : UNCACHE;
            MISS, UNCACHE: if (axi_ret_valid) state <= IDLE;
            default:       state <= IDLE;
         endcase
      end
   end
`endif

endmodule
